// File: rtl/spi_slave_pkg.sv
// Shared SPI mode constants, state encoding and TX-byte selection helper
// for the spi_slave responder.
package spi_slave_pkg;

  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;
  localparam bit CAPTURE_ON_RISE = (SPI_CPOL == SPI_CPHA);

  localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  function automatic logic [7:0] next_tx_byte(input logic       full,
                                              input logic [7:0] data,
                                              input logic [7:0] fill);
    return full ? data : fill;
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Byte-level user handshake of spi_slave: TX buffer write, RX byte read, frame status.
interface spi_slave_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, busy
  );

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// STAGES-deep synchroniser for an asynchronous pin, with registered
// one-cycle rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // The chain is not reset: a reset during an active frame must not fabricate an edge.
  always_ff @(posedge sys_clk) begin
    sync_q <= {sync_q[STAGES-2:0], din};
    prev_q <= sync_q[STAGES-1];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= sync_q[STAGES-1] & ~prev_q;
      fall <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder oversampled in sys_clk; byte-wide valid/ready user side.
// Optional sticky error flags when SPI_SLAVE_ERR_EN is defined.
//   state     | meaning
//   ST_IDLE   | deselected; sck edges ignored, miso_oe low
//   ST_ACTIVE | frame in progress; capture mosi on rise, launch miso on fall
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = DEFAULT_FILL_BYTE
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
`ifdef SPI_SLAVE_ERR_EN
  input  logic       err_clr,
  output logic       err_overrun,
  output logic       err_underrun,
  output logic       err_abort,
`endif
  spi_slave_if.slave usr
);

  logic                   sck_s, sck_rise, sck_fall;
  logic                   cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;
  logic                   capture, launch;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic       reload_q;
  logic       byte_done_q;
  logic [6:0] tx_rest_q;
  logic [7:0] rx_shift_q;
  logic [7:0] tx_buf_q;
  logic       tx_full_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       busy_q;
  logic       load_tx;
  logic [7:0] load_byte;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .din     (sck),
    .dout    (sck_s),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .din     (cs_n),
    .dout    (cs_s),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  always_ff @(posedge sys_clk) begin
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // An edge pulse whose level has already reverted is a runt and is dropped.
  assign capture = CAPTURE_ON_RISE ? (sck_rise &  sck_s) : (sck_fall & ~sck_s);
  assign launch  = CAPTURE_ON_RISE ? (sck_fall & ~sck_s) : (sck_rise &  sck_s);

  always_comb begin
    load_tx = 1'b0;
    if (state_q == ST_IDLE) load_tx = cs_fall;
    else                    load_tx = !cs_rise && launch && reload_q;
  end

  assign load_byte = next_tx_byte(tx_full_q, tx_buf_q, FILL_BYTE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      reload_q    <= 1'b0;
      byte_done_q <= 1'b0;
      tx_rest_q   <= 7'd0;
      rx_shift_q  <= 8'd0;
      tx_buf_q    <= 8'd0;
      tx_full_q   <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      busy_q      <= ~cs_s;
      byte_done_q <= 1'b0;

      // A load in the same cycle as a write sees the pre-write buffer state.
      if (load_tx && tx_full_q) begin
        tx_full_q <= 1'b0;
      end else if (usr.tx_valid && !tx_full_q) begin
        tx_full_q <= 1'b1;
        tx_buf_q  <= usr.tx_data;
      end

      if (byte_done_q) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && usr.rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_ACTIVE;
            miso      <= load_byte[7];
            tx_rest_q <= load_byte[6:0];
            miso_oe   <= 1'b1;
            bit_cnt_q <= 3'd0;
            reload_q  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state_q   <= ST_IDLE;
            miso_oe   <= 1'b0;
            bit_cnt_q <= 3'd0;
            reload_q  <= 1'b0;
          end else begin
            if (capture) begin
              rx_shift_q <= {rx_shift_q[6:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                byte_done_q <= 1'b1;
                reload_q    <= 1'b1;
              end
            end
            if (launch) begin
              if (reload_q) begin
                miso      <= load_byte[7];
                tx_rest_q <= load_byte[6:0];
                reload_q  <= 1'b0;
              end else begin
                miso      <= tx_rest_q[6];
                tx_rest_q <= {tx_rest_q[5:0], 1'b0};
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign usr.tx_ready = ~tx_full_q;
  assign usr.rx_data  = rx_data_q;
  assign usr.rx_valid = rx_valid_q;
  assign usr.busy     = busy_q;

`ifdef SPI_SLAVE_ERR_EN
  logic ovr_evt, udr_evt, abt_evt;

  assign ovr_evt = byte_done_q && rx_valid_q && !usr.rx_ready;
  assign udr_evt = load_tx && !tx_full_q;
  assign abt_evt = (state_q == ST_ACTIVE) && cs_rise && (bit_cnt_q != 3'd0);

  // Set events win over a simultaneous clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_overrun  <= 1'b0;
      err_underrun <= 1'b0;
      err_abort    <= 1'b0;
    end else begin
      err_overrun  <= ovr_evt | (err_overrun  & ~err_clr);
      err_underrun <= udr_evt | (err_underrun & ~err_clr);
      err_abort    <= abt_evt | (err_abort    & ~err_clr);
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed + randomized bench for spi_slave, acting as mode-0 SPI master and byte-level user.
module tb_spi_slave;

  localparam int         SYNC  = 2;
  localparam int         H_MIN = SYNC + 2;
  localparam logic [7:0] FILL  = 8'hFF;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic sck, cs_n, mosi;
  logic miso, miso_oe;
`ifdef SPI_SLAVE_ERR_EN
  logic err_clr, err_overrun, err_underrun, err_abort;
`endif

  spi_slave_if u_if ();

  spi_slave #(.SYNC_STAGES(SYNC), .FILL_BYTE(FILL)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sck          (sck),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe),
`ifdef SPI_SLAVE_ERR_EN
    .err_clr      (err_clr),
    .err_overrun  (err_overrun),
    .err_underrun (err_underrun),
    .err_abort    (err_abort),
`endif
    .usr          (u_if)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one-entry TX buffer, expected miso bytes, expected RX bytes, error flags.
  logic [7:0] mdl_buf;
  bit         mdl_full;
  bit         mdl_underrun, mdl_overrun, mdl_abort;
  bit         mdl_rx_pending;
  logic [7:0] exp_q[$];
  logic [7:0] rx_exp[$];
  logic [7:0] rx_got[$];

  always @(negedge sys_clk) begin
    if (!sys_rst && u_if.rx_valid && u_if.rx_ready) rx_got.push_back(u_if.rx_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic mdl_take(output logic [7:0] b);
    if (mdl_full) begin
      b = mdl_buf;
      mdl_full = 1'b0;
    end else begin
      b = FILL;
      mdl_underrun = 1'b1;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    int waited;
    waited = 0;
    while (u_if.tx_ready !== 1'b1 && waited < 50) begin
      tick(1);
      waited++;
    end
    check("tx_ready_wait", u_if.tx_ready, 1);
    u_if.tx_data  = d;
    u_if.tx_valid = 1'b1;
    tick(1);
    u_if.tx_valid = 1'b0;
    if (!mdl_full) begin
      mdl_buf  = d;
      mdl_full = 1'b1;
    end
  endtask

  task automatic cs_lo(input int h);
    logic [7:0] b;
    cs_n = 1'b0;
    mdl_take(b);
    exp_q.push_back(b);
    tick(h);
  endtask

  task automatic cs_hi(input int h, input bit partial);
    tick(h);
    cs_n = 1'b1;
    if (partial) mdl_abort = 1'b1;
    exp_q.delete();
    tick(SYNC + 4);
  endtask

  task automatic xfer_bits(input logic [7:0] mo, input int nbits, input int h,
                           input bit chk_lat, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      tick(h);
      mi[i] = miso;
      sck = 1'b1;
      tick(h);
      if (chk_lat && i == 0) check("rx_lat_early", u_if.rx_valid, 0);
      sck = 1'b0;
    end
    if (chk_lat) begin
      tick(1);
      check("rx_lat_exact", u_if.rx_valid, 1);
    end
  endtask

  task automatic do_byte(input logic [7:0] mo, input int h, input bit chk_lat, input string tag);
    logic [7:0] mi, exp;
    xfer_bits(mo, 8, h, chk_lat, mi);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_miso"}, mi, exp);
    mdl_take(exp);
    exp_q.push_back(exp);
    if (u_if.rx_ready) begin
      rx_exp.push_back(mo);
    end else begin
      if (mdl_rx_pending) mdl_overrun = 1'b1;
      mdl_rx_pending = 1'b1;
    end
  endtask

  task automatic rx_take(input string tag);
    u_if.rx_ready = 1'b1;
    tick(1);
    u_if.rx_ready = 1'b0;
    mdl_rx_pending = 1'b0;
    check(tag, u_if.rx_valid, 0);
  endtask

`ifdef SPI_SLAVE_ERR_EN
  task automatic err_check(input string tag);
    check({tag, "_err_ovr"}, err_overrun,  mdl_overrun);
    check({tag, "_err_udr"}, err_underrun, mdl_underrun);
    check({tag, "_err_abt"}, err_abort,    mdl_abort);
  endtask

  task automatic err_clear();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    mdl_underrun = 1'b0;
    mdl_overrun  = 1'b0;
    mdl_abort    = 1'b0;
    err_check("clr");
  endtask
`endif

  logic [7:0] r1, r2, mi;
  int         h, nb;

  initial begin
    sys_rst = 1'b1;
    sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    u_if.tx_data = 8'h00; u_if.tx_valid = 1'b0; u_if.rx_ready = 1'b0;
`ifdef SPI_SLAVE_ERR_EN
    err_clr = 1'b0;
`endif
    mdl_full = 1'b0; mdl_buf = 8'h00; mdl_rx_pending = 1'b0;
    mdl_underrun = 1'b0; mdl_overrun = 1'b0; mdl_abort = 1'b0;
    tick(6);
    check("rst_miso",     miso, 0);
    check("rst_miso_oe",  miso_oe, 0);
    check("rst_tx_ready", u_if.tx_ready, 1);
    check("rst_rx_data",  u_if.rx_data, 0);
    check("rst_rx_valid", u_if.rx_valid, 0);
    check("rst_busy",     u_if.busy, 0);
    sys_rst = 1'b0;
    tick(SYNC + 4);

    // Single byte: A5 out, 3C in, exact rx latency at minimum half-period
    tx_write(8'hA5);
    check("t1_tx_full", u_if.tx_ready, 0);
    cs_lo(H_MIN);
    check("t1_tx_ready", u_if.tx_ready, 1);
    check("t1_oe",       miso_oe, 1);
    check("t1_busy",     u_if.busy, 1);
    do_byte(8'h3C, H_MIN, 1'b1, "t1");
    cs_hi(H_MIN, 1'b0);
    check("t1_rx_data",  u_if.rx_data, 8'h3C);
    check("t1_rx_valid", u_if.rx_valid, 1);
    check("t1_oe_off",   miso_oe, 0);
    check("t1_busy_off", u_if.busy, 0);
    rx_take("t1_rx_clr");
`ifdef SPI_SLAVE_ERR_EN
    err_clear();
`endif

    // Two bytes with one buffered: 55 then fill
    tx_write(8'h55);
    cs_lo(H_MIN + 1);
    do_byte(8'h01, H_MIN + 1, 1'b0, "t2b0");
    do_byte(8'h80, H_MIN + 1, 1'b0, "t2b1");
    cs_hi(H_MIN + 1, 1'b0);
    check("t2_rx_data", u_if.rx_data, 8'h80);
`ifdef SPI_SLAVE_ERR_EN
    err_check("t2");
    err_clear();
`endif
    rx_take("t2_rx_clr");

    // Overrun: two random bytes with rx_ready held low
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    cs_lo(H_MIN + 2);
    do_byte(r1, H_MIN + 2, 1'b0, "t3b0");
    do_byte(r2, H_MIN + 2, 1'b0, "t3b1");
    cs_hi(H_MIN + 2, 1'b0);
    check("t3_rx_data",  u_if.rx_data, r2);
    check("t3_rx_valid", u_if.rx_valid, 1);
`ifdef SPI_SLAVE_ERR_EN
    err_check("t3");
    err_clear();
`endif
    rx_take("t3_rx_clr");

    // Abort after 5 bits, then a full C3 frame
    cs_lo(H_MIN);
    xfer_bits(8'hA8, 5, H_MIN, 1'b0, mi);
    r1 = exp_q[0];
    check("t4_partial_miso", mi[7:3], r1[7:3]);
    cs_hi(H_MIN, 1'b1);
    check("t4_no_rx", u_if.rx_valid, 0);
`ifdef SPI_SLAVE_ERR_EN
    err_check("t4");
    err_clear();
`endif
    cs_lo(H_MIN);
    do_byte(8'hC3, H_MIN, 1'b0, "t4b");
    cs_hi(H_MIN, 1'b0);
    check("t4_rx_data",  u_if.rx_data, 8'hC3);
    check("t4_rx_valid", u_if.rx_valid, 1);

    // Reset mid-byte with rx pending and buffer full
    cs_lo(H_MIN);
    tx_write(8'h9A);
    xfer_bits(8'hF0, 4, H_MIN, 1'b0, mi);
    sys_rst = 1'b1;
    tick(1);
    check("t5_miso",     miso, 0);
    check("t5_oe",       miso_oe, 0);
    check("t5_tx_ready", u_if.tx_ready, 1);
    check("t5_rx_data",  u_if.rx_data, 0);
    check("t5_rx_valid", u_if.rx_valid, 0);
    check("t5_busy",     u_if.busy, 0);
    tick(1);
    sys_rst = 1'b0;
    cs_n = 1'b1;
    mdl_full = 1'b0; mdl_rx_pending = 1'b0;
    mdl_underrun = 1'b0; mdl_overrun = 1'b0; mdl_abort = 1'b0;
    exp_q.delete();
    tick(SYNC + 4);
`ifdef SPI_SLAVE_ERR_EN
    err_check("t5_rst");
`endif
    cs_lo(H_MIN);
    do_byte(8'h7E, H_MIN, 1'b0, "t5b");
    cs_hi(H_MIN, 1'b0);
    check("t5_rx_after", u_if.rx_data, 8'h7E);
    rx_take("t5_rx_clr");
`ifdef SPI_SLAVE_ERR_EN
    err_clear();
`endif

    // Back-to-back TX at minimum half-period
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    tx_write(8'h11);
    cs_lo(H_MIN);
    check("t6_tx_ready", u_if.tx_ready, 1);
    tx_write(8'h22);
    do_byte(r1, H_MIN, 1'b0, "t6b0");
    do_byte(r2, H_MIN, 1'b0, "t6b1");
    cs_hi(H_MIN, 1'b0);
    check("t6_rx_data", u_if.rx_data, r2);
    rx_take("t6_rx_clr");
`ifdef SPI_SLAVE_ERR_EN
    err_clear();
`endif

    // Randomized frames with a consumer that is always ready
    u_if.rx_ready = 1'b1;
    rx_got.delete();
    rx_exp.delete();
    for (int k = 0; k < 6; k++) begin
      h  = $urandom_range(SYNC + 5, SYNC + 2);
      nb = $urandom_range(3, 1);
      if ($urandom_range(1, 0) == 1) tx_write(8'($urandom));
      cs_lo(h);
      for (int j = 0; j < nb; j++) do_byte(8'($urandom), h, 1'b0, "rand");
      cs_hi(h, 1'b0);
      check("rand_rx_cnt", rx_got.size(), rx_exp.size());
      for (int j = 0; j < rx_exp.size() && j < rx_got.size(); j++)
        check("rand_rx_data", rx_got[j], rx_exp[j]);
      rx_got.delete();
      rx_exp.delete();
`ifdef SPI_SLAVE_ERR_EN
      err_check("rand");
      err_clear();
`endif
    end
    u_if.rx_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
